// File: rtl/abacus_pkg.sv
// Shared definitions for the line-fill latency profiler.
// Contents:
//   state_e              - profiler FSM states (idle / measuring a fill)
//   HistThr1..HistThr3   - latency histogram bin boundaries (8, 16, 32 cycles)
package abacus_pkg;

    typedef enum logic {
        StIdle,
        StMeasure
    } state_e;

    localparam int unsigned HistThr1 = 8;
    localparam int unsigned HistThr2 = 16;
    localparam int unsigned HistThr3 = 32;

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator: adds 'add' when 'inc' is high, sticks at all-ones.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   clear      - synchronous zero, wins over inc
//   inc        - accumulate this cycle
//   add [W]    - addend
//   value [W]  - current accumulated value
module sat_accum #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] add,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q, value_d;
    logic [W:0]   sum;

    // One extra bit catches the carry out for saturation.
    assign sum = {1'b0, value_q} + {1'b0, add};

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc) begin
            value_d = sum[W] ? '1 : sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/line_fill_latency_profiler.sv
// Measures cache line-fill durations (cycles the fill level is sampled high)
// and keeps count, total, max, last and an optional latency histogram.
// Optional feature macro: ABACUS_LATENCY_HISTOGRAM_EN (histogram bins);
// without it hist_bin0..3 are constant zero.
// Ports:
//   clk, rst                 - rising-edge clock, synchronous active-high reset
//   enable                   - profiling enable; outputs hold while low
//   clear                    - synchronous zero of all accumulators, aborts a fill
//   line_fill_in_progress    - fill-active level from the core
//   fill_count               - committed fills
//   total_latency            - sum of committed fill lengths
//   max_latency, last_latency - longest / most recent committed fill
//   busy                     - a fill is being measured
//   hist_bin0..3             - fills <8, 8-15, 16-31, >=32 cycles
module line_fill_latency_profiler
    import abacus_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             line_fill_in_progress,
    output logic [CNT_W-1:0] fill_count,
    output logic [CNT_W-1:0] total_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] last_latency,
    output logic             busy,
    output logic [CNT_W-1:0] hist_bin0,
    output logic [CNT_W-1:0] hist_bin1,
    output logic [CNT_W-1:0] hist_bin2,
    output logic [CNT_W-1:0] hist_bin3
);

    state_e           state_q, state_d;
    logic             fill_q;
    logic             armed_q;
    logic [CNT_W-1:0] cur_len_q, cur_len_d;
    logic [CNT_W-1:0] max_q, last_q;
    logic             start, fill_end, commit;

    // armed_q: the input has been seen low since reset, so a rising level is a
    // genuine new fill rather than one that was already running through reset.
    assign start    = armed_q & ~fill_q & line_fill_in_progress;
    assign fill_end = fill_q & ~line_fill_in_progress;

    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && enable && !clear) begin
                    state_d   = StMeasure;
                    cur_len_d = CNT_W'(1);
                end
            end
            StMeasure: begin
                if (clear || !enable) begin
                    state_d   = StIdle;
                    cur_len_d = '0;
                end else if (fill_end) begin
                    state_d   = StIdle;
                    cur_len_d = '0;
                    commit    = 1'b1;
                end else if (cur_len_q != '1) begin
                    cur_len_d = cur_len_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            fill_q    <= 1'b0;
            armed_q   <= ~line_fill_in_progress;
            cur_len_q <= '0;
            max_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= line_fill_in_progress;
            armed_q   <= armed_q | ~line_fill_in_progress;
            cur_len_q <= cur_len_d;
            if (clear) begin
                max_q  <= '0;
                last_q <= '0;
            end else if (commit) begin
                last_q <= cur_len_q;
                if (cur_len_q > max_q) begin
                    max_q <= cur_len_q;
                end
            end
        end
    end

    sat_accum #(.W(CNT_W)) u_fill_count (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (commit),
        .add   (CNT_W'(1)),
        .value (fill_count)
    );

    sat_accum #(.W(CNT_W)) u_total_latency (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (commit),
        .add   (cur_len_q),
        .value (total_latency)
    );

    assign max_latency  = max_q;
    assign last_latency = last_q;
    assign busy         = (state_q == StMeasure);

`ifdef ABACUS_LATENCY_HISTOGRAM_EN
    logic [3:0]       bin_hit;
    logic [CNT_W-1:0] bins [4];

    always_comb begin
        bin_hit = '0;
        if (cur_len_q < CNT_W'(HistThr1)) begin
            bin_hit[0] = 1'b1;
        end else if (cur_len_q < CNT_W'(HistThr2)) begin
            bin_hit[1] = 1'b1;
        end else if (cur_len_q < CNT_W'(HistThr3)) begin
            bin_hit[2] = 1'b1;
        end else begin
            bin_hit[3] = 1'b1;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bin
        sat_accum #(.W(CNT_W)) u_bin (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .inc   (commit & bin_hit[b]),
            .add   (CNT_W'(1)),
            .value (bins[b])
        );
    end

    assign hist_bin0 = bins[0];
    assign hist_bin1 = bins[1];
    assign hist_bin2 = bins[2];
    assign hist_bin3 = bins[3];
`else
    assign hist_bin0 = '0;
    assign hist_bin1 = '0;
    assign hist_bin2 = '0;
    assign hist_bin3 = '0;
`endif

endmodule

// File: tb/tb_line_fill_latency_profiler.sv
// Self-checking bench for line_fill_latency_profiler (CNT_W=8).
// A fill-level reference model tracks expected outputs; a negedge process
// compares every output each cycle, and directed scenarios pin literal values.
module tb_line_fill_latency_profiler;

    localparam int unsigned W = 8;
    localparam longint MaxV = 255;
`ifdef ABACUS_LATENCY_HISTOGRAM_EN
    localparam bit HistEn = 1'b1;
`else
    localparam bit HistEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, enable, clear, lfip;
    logic [W-1:0] fill_count, total_latency, max_latency, last_latency;
    logic         busy;
    logic [W-1:0] hist_bin0, hist_bin1, hist_bin2, hist_bin3;

    line_fill_latency_profiler #(.CNT_W(W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable                (enable),
        .clear                 (clear),
        .line_fill_in_progress (lfip),
        .fill_count            (fill_count),
        .total_latency         (total_latency),
        .max_latency           (max_latency),
        .last_latency          (last_latency),
        .busy                  (busy),
        .hist_bin0             (hist_bin0),
        .hist_bin1             (hist_bin1),
        .hist_bin2             (hist_bin2),
        .hist_bin3             (hist_bin3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: follows each fill as a whole (length so far), commits it
    // when the level drops, and applies saturating arithmetic to the totals.
    longint m_count, m_total, m_max, m_last, m_run;
    longint m_bin [4];
    bit     m_meas, m_prev, m_low_seen;

    function automatic longint sat(input longint v);
        return (v > MaxV) ? MaxV : v;
    endfunction

    function automatic int bin_of(input longint len);
        if (len < 8) return 0;
        if (len < 16) return 1;
        if (len < 32) return 2;
        return 3;
    endfunction

    task automatic model_zero();
        m_count = 0; m_total = 0; m_max = 0; m_last = 0; m_meas = 0; m_run = 0;
        for (int b = 0; b < 4; b++) m_bin[b] = 0;
    endtask

    initial begin
        model_zero();
        m_prev = 0;
        m_low_seen = 0;
    end

    always @(posedge clk) begin
        bit new_fill;
        if (rst === 1'b1) begin
            model_zero();
            m_prev     = 0;
            m_low_seen = !lfip;
        end else begin
            new_fill = m_low_seen && !m_prev && lfip;
            if (clear) begin
                model_zero();
            end else if (m_meas) begin
                if (!enable) begin
                    m_meas = 0;
                end else if (!lfip) begin
                    m_count = sat(m_count + 1);
                    m_total = sat(m_total + m_run);
                    m_last  = m_run;
                    if (m_run > m_max) m_max = m_run;
                    if (HistEn) m_bin[bin_of(m_run)] = sat(m_bin[bin_of(m_run)] + 1);
                    m_meas = 0;
                end else begin
                    m_run = sat(m_run + 1);
                end
            end else if (new_fill && enable) begin
                m_meas = 1;
                m_run  = 1;
            end
            m_prev = lfip;
            if (!lfip) m_low_seen = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("fill_count", fill_count, m_count);
            chk("total_latency", total_latency, m_total);
            chk("max_latency", max_latency, m_max);
            chk("last_latency", last_latency, m_last);
            chk("busy", busy, m_meas);
            chk("hist_bin0", hist_bin0, m_bin[0]);
            chk("hist_bin1", hist_bin1, m_bin[1]);
            chk("hist_bin2", hist_bin2, m_bin[2]);
            chk("hist_bin3", hist_bin3, m_bin[3]);
        end
    end

    task automatic cyc(input bit r, input bit e, input bit c, input bit i);
        @(negedge clk);
        rst = r; enable = e; clear = c; lfip = i;
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Literal check against both the DUT and the model.
    task automatic lit(input string nm, input longint act, input longint mdl,
                       input longint exp);
        chk({nm, " (dut)"}, act, exp);
        chk({nm, " (model)"}, mdl, exp);
    endtask

    initial begin
        bit e, i;
        rst = 1; enable = 0; clear = 0; lfip = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        settle();
        chk_on = 1'b1;
        lit("reset count", fill_count, m_count, 0);
        lit("reset total", total_latency, m_total, 0);
        lit("reset busy", busy, m_meas, 0);

        // Single 5-cycle fill
        cyc(0, 1, 0, 0);
        fill(5);
        settle();
        lit("f5 count", fill_count, m_count, 1);
        lit("f5 total", total_latency, m_total, 5);
        lit("f5 last", last_latency, m_last, 5);
        lit("f5 max", max_latency, m_max, 5);
        lit("f5 bin0", hist_bin0, m_bin[0], HistEn ? 1 : 0);

        // 10 then 3, separated by a single low cycle
        cyc(0, 1, 1, 0);
        fill(10);
        fill(3);
        settle();
        lit("f10f3 count", fill_count, m_count, 2);
        lit("f10f3 total", total_latency, m_total, 13);
        lit("f10f3 max", max_latency, m_max, 10);
        lit("f10f3 last", last_latency, m_last, 3);
        lit("f10f3 bin1", hist_bin1, m_bin[1], HistEn ? 1 : 0);
        lit("f10f3 bin0", hist_bin0, m_bin[0], HistEn ? 1 : 0);

        // Enable dropped mid-fill, then enable rising while the level is high
        cyc(0, 1, 1, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 1);
        settle();
        lit("abort busy", busy, m_meas, 0);
        lit("abort count", fill_count, m_count, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
        settle();
        lit("late-enable count", fill_count, m_count, 0);
        lit("late-enable total", total_latency, m_total, 0);

        // Clear on the end cycle of a 6-cycle fill
        fill(4);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 0);
        settle();
        lit("clr-end count", fill_count, m_count, 0);
        lit("clr-end total", total_latency, m_total, 0);
        lit("clr-end max", max_latency, m_max, 0);
        lit("clr-end last", last_latency, m_last, 0);

        // Total saturation at 8 bits
        for (int k = 0; k < 5; k++) fill(50);
        fill(10);
        settle();
        lit("sat total", total_latency, m_total, 255);
        lit("sat count", fill_count, m_count, 6);
        lit("sat last", last_latency, m_last, 10);

        // Reset mid-fill; the continuing fill is ignored
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(1, 1, 0, 1);
        settle();
        lit("rst count", fill_count, m_count, 0);
        lit("rst total", total_latency, m_total, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
        settle();
        lit("post-rst count", fill_count, m_count, 0);
        lit("post-rst busy", busy, m_meas, 0);
        fill(40);
        settle();
        lit("f40 count", fill_count, m_count, 1);
        lit("f40 total", total_latency, m_total, 40);
        lit("f40 bin3", hist_bin3, m_bin[3], HistEn ? 1 : 0);

        // Fill longer than the counter range: length saturates
        fill(300);
        settle();
        lit("long last", last_latency, m_last, 255);
        lit("long max", max_latency, m_max, 255);
        lit("long count", fill_count, m_count, 2);

        // Random traffic checked by the model every cycle
        e = 1; i = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 59) == 0) e = !e;
            if ($urandom_range(0, 5) == 0) i = !i;
            cyc(($urandom_range(0, 499) == 0), e, ($urandom_range(0, 119) == 0), i);
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
